sample_averager: RTL and testbench

Consumer stage sitting directly downstream of the ADC/EPROM filtering producer: accepts the 8-bit filtered samples it emits over the dav_/rfd handshake, groups them in blocks of 2^GROUP_LOG2, and for each block publishes the truncated mean and the peak value. Results go to the next stage over an identical dav_/rfd handshake, with this block acting as producer. The block does not accept a new input sample while a result is pending downstream.

---
 rtl/sample_averager.sv | 117 +++++++++++
 tb/tb_sample_averager.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/sample_averager.sv
// sample_averager
//   Consumes 8-bit samples over an active-low dav_/rfd handshake, groups them
//   in blocks of 2**GROUP_LOG2, and publishes the truncated mean and the peak
//   of each block downstream over the same handshake (this block as producer).
//   No new sample is accepted while a result is pending downstream.
//
// Ports
//   clock     system clock, all logic on posedge
//   reset     synchronous, active-high
//   dav_in_   upstream data valid (active low)
//   d_in      upstream sample, unsigned
//   rfd_in    ready-for-data to upstream (active high)
//   dav_out_  result valid to downstream (active low)
//   rfd_out   downstream ready-for-data
//   avg       block mean, floor(sum / N)
//   peak      block maximum
module sample_averager #(
    parameter int GROUP_LOG2 = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       dav_in_,
    input  logic [7:0] d_in,
    output logic       rfd_in,
    output logic       dav_out_,
    input  logic       rfd_out,
    output logic [7:0] avg,
    output logic [7:0] peak
);
    localparam int SW = 8 + GROUP_LOG2;
    // A zero-width counter is illegal, so GROUP_LOG2 = 0 keeps one bit that never moves.
    localparam int CW = (GROUP_LOG2 > 0) ? GROUP_LOG2 : 1;
    localparam logic [CW-1:0] LAST = CW'((1 << GROUP_LOG2) - 1);

    typedef enum logic [1:0] {W0, W1, O0, O1} state_t;

    state_t        state, state_n;
    logic [SW-1:0] sum, sum_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [7:0]    pk, pk_n;
    logic          rfd_n, dav_n;
    logic [7:0]    avg_n, peak_n;
    logic [7:0]    mean;

    // Sum is wide enough that the shifted mean always fits in 8 bits.
    assign mean = 8'(sum >> GROUP_LOG2);

    always_comb begin
        state_n = state;
        sum_n   = sum;
        cnt_n   = cnt;
        pk_n    = pk;
        rfd_n   = rfd_in;
        dav_n   = dav_out_;
        avg_n   = avg;
        peak_n  = peak;
        case (state)
            W0: if (!dav_in_) begin
                sum_n   = sum + SW'(d_in);
                pk_n    = (d_in > pk) ? d_in : pk;
                rfd_n   = 1'b0;
                state_n = W1;
            end
            // One capture per handshake: wait here until upstream releases dav_in_.
            W1: if (dav_in_) begin
                if (cnt == LAST) begin
                    state_n = O0;
                end else begin
                    cnt_n   = cnt + CW'(1);
                    rfd_n   = 1'b1;
                    state_n = W0;
                end
            end
            // Data and dav_out_ go out on the same edge; rewritten each cycle
            // with identical values so they stay stable while dav_out_ is low.
            O0: begin
                avg_n  = mean;
                peak_n = pk;
                dav_n  = 1'b0;
                if (!rfd_out) state_n = O1;
            end
            O1: begin
                dav_n = 1'b1;
                if (rfd_out) begin
                    sum_n   = '0;
                    pk_n    = '0;
                    cnt_n   = '0;
                    rfd_n   = 1'b1;
                    state_n = W0;
                end
            end
            default: state_n = W0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= W0;
            sum      <= '0;
            cnt      <= '0;
            pk       <= '0;
            rfd_in   <= 1'b1;
            dav_out_ <= 1'b1;
            avg      <= '0;
            peak     <= '0;
        end else begin
            state    <= state_n;
            sum      <= sum_n;
            cnt      <= cnt_n;
            pk       <= pk_n;
            rfd_in   <= rfd_n;
            dav_out_ <= dav_n;
            avg      <= avg_n;
            peak     <= peak_n;
        end
    end
endmodule

// File: tb/tb_sample_averager.sv
module tb_sample_averager;
    logic       clock = 1'b0;
    logic       reset;
    logic       dav_in_, rfd_out;
    logic [7:0] d_in;
    logic       rfd_in, dav_out_;
    logic [7:0] avg, peak;

    // GROUP_LOG2 = 0 instance with its own signals
    logic       dav0_, rfd_out0;
    logic [7:0] d0;
    logic       rfd_in0, dav_out0_;
    logic [7:0] avg0, peak0;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    sample_averager #(.GROUP_LOG2(2)) dut (
        .clock(clock), .reset(reset), .dav_in_(dav_in_), .d_in(d_in),
        .rfd_in(rfd_in), .dav_out_(dav_out_), .rfd_out(rfd_out),
        .avg(avg), .peak(peak)
    );

    sample_averager #(.GROUP_LOG2(0)) dut0 (
        .clock(clock), .reset(reset), .dav_in_(dav0_), .d_in(d0),
        .rfd_in(rfd_in0), .dav_out_(dav_out0_), .rfd_out(rfd_out0),
        .avg(avg0), .peak(peak0)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One upstream handshake: capture edge, then release edge.
    task automatic send(input logic [7:0] d);
        int n = 0;
        while (rfd_in !== 1'b1 && n < 100) begin tick(); n++; end
        check("send_rdy", {7'd0, rfd_in}, 8'd1);
        d_in    = d;
        dav_in_ = 1'b0;
        tick();
        dav_in_ = 1'b1;
        tick();
    endtask

    // Full downstream handshake with data check.
    task automatic take(input string tag, input logic [7:0] ea, input logic [7:0] ep);
        int n = 0;
        while (dav_out_ !== 1'b0 && n < 100) begin tick(); n++; end
        check({tag, "_dav"}, {7'd0, dav_out_}, 8'd0);
        check({tag, "_avg"}, avg, ea);
        check({tag, "_peak"}, peak, ep);
        rfd_out = 1'b0;
        tick();
        tick();
        n = 0;
        while (dav_out_ !== 1'b1 && n < 100) begin tick(); n++; end
        check({tag, "_rel"}, {7'd0, dav_out_}, 8'd1);
        check({tag, "_bp"}, {7'd0, rfd_in}, 8'd0);
        rfd_out = 1'b1;
        tick();
        check({tag, "_rfd"}, {7'd0, rfd_in}, 8'd1);
    endtask

    initial begin
        logic ok;
        reset = 1'b1; dav_in_ = 1'b1; rfd_out = 1'b1; d_in = 8'd0;
        dav0_ = 1'b1; rfd_out0 = 1'b1; d0 = 8'd0;
        tick(); tick();
        reset = 1'b0;
        check("rst_rfd", {7'd0, rfd_in}, 8'd1);
        check("rst_dav", {7'd0, dav_out_}, 8'd1);
        check("rst_avg", avg, 8'd0);
        check("rst_peak", peak, 8'd0);

        // Basic block, latency and backpressure
        send(8'd10); send(8'd20); send(8'd30);
        check("b3_dav", {7'd0, dav_out_}, 8'd1);
        send(8'd41);
        check("lat1", {7'd0, dav_out_}, 8'd1);
        tick();
        check("lat2", {7'd0, dav_out_}, 8'd0);
        check("lat_rfd", {7'd0, rfd_in}, 8'd0);
        take("basic", 8'd25, 8'd41);

        // Saturation, then cleared accumulators
        repeat (4) send(8'd255);
        take("sat", 8'd255, 8'd255);
        send(8'd0); send(8'd0); send(8'd0); send(8'd3);
        take("clr", 8'd0, 8'd3);

        // Slow consumer with an upstream pulse offered while result is pending
        send(8'd5); send(8'd6); send(8'd7); send(8'd8);
        tick();
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin d_in = 8'd250; dav_in_ = 1'b0; end
            if (i == 7) dav_in_ = 1'b1;
            tick();
            if (dav_out_ !== 1'b0 || avg !== 8'd6 || peak !== 8'd8 || rfd_in !== 1'b0) ok = 1'b0;
        end
        check("slow_hold", {7'd0, ok}, 8'd1);
        take("slow", 8'd6, 8'd8);
        send(8'd1); send(8'd1); send(8'd1); send(8'd1);
        take("after_slow", 8'd1, 8'd1);

        // Long dav_in_ hold: only the first sampled value counts
        d_in = 8'd100;
        dav_in_ = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (rfd_in !== 1'b0) ok = 1'b0;
            d_in = 8'(101 + i);
        end
        check("hold_rfd", {7'd0, ok}, 8'd1);
        dav_in_ = 1'b1;
        tick();
        send(8'd0); send(8'd0);
        check("hold_cnt", {7'd0, dav_out_}, 8'd1);
        send(8'd0);
        take("hold", 8'd25, 8'd100);

        // Reset mid-group discards the partial block
        send(8'd200); send(8'd200);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mr_rfd", {7'd0, rfd_in}, 8'd1);
        check("mr_dav", {7'd0, dav_out_}, 8'd1);
        check("mr_avg", avg, 8'd0);
        check("mr_peak", peak, 8'd0);
        send(8'd1); send(8'd2); send(8'd3); send(8'd4);
        take("mr", 8'd2, 8'd4);

        // GROUP_LOG2 = 0: each sample is its own block
        d0 = 8'd7; dav0_ = 1'b0; tick();
        dav0_ = 1'b1; tick(); tick();
        check("g0a_dav", {7'd0, dav_out0_}, 8'd0);
        check("g0a_avg", avg0, 8'd7);
        check("g0a_peak", peak0, 8'd7);
        rfd_out0 = 1'b0; tick(); tick();
        rfd_out0 = 1'b1; tick();
        check("g0a_rfd", {7'd0, rfd_in0}, 8'd1);
        d0 = 8'd99; dav0_ = 1'b0; tick();
        dav0_ = 1'b1; tick(); tick();
        check("g0b_dav", {7'd0, dav_out0_}, 8'd0);
        check("g0b_avg", avg0, 8'd99);
        check("g0b_peak", peak0, 8'd99);
        rfd_out0 = 1'b0; tick(); tick();
        rfd_out0 = 1'b1; tick();
        check("g0b_rfd", {7'd0, rfd_in0}, 8'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
